// File: rtl/ext_mem_rr_merge.sv
// Two-master to one-slave native-bus merge: round-robin grant, combinational forward, in-order read-ID FIFO routes responses.
// Optional EXT_MEM_MERGE_FIXED_PRIO_EN: m1 always wins contention and the priority pointer register is removed.
module ext_mem_rr_merge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int PEND_W = 2
) (
   input  logic                clk_i,
   input  logic                cke_i,
   input  logic                rst_i,
   input  logic                m0_avalid_i,
   input  logic [ADDR_W-1:0]   m0_addr_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   input  logic [DATA_W/8-1:0] m0_wstrb_i,
   output logic [DATA_W-1:0]   m0_rdata_o,
   output logic                m0_rvalid_o,
   output logic                m0_ready_o,
   input  logic                m1_avalid_i,
   input  logic [ADDR_W-1:0]   m1_addr_i,
   input  logic [DATA_W-1:0]   m1_wdata_i,
   input  logic [DATA_W/8-1:0] m1_wstrb_i,
   output logic [DATA_W-1:0]   m1_rdata_o,
   output logic                m1_rvalid_o,
   output logic                m1_ready_o,
   output logic                s_avalid_o,
   output logic [ADDR_W-1:0]   s_addr_o,
   output logic [DATA_W-1:0]   s_wdata_o,
   output logic [DATA_W/8-1:0] s_wstrb_o,
   input  logic [DATA_W-1:0]   s_rdata_i,
   input  logic                s_rvalid_i,
   input  logic                s_ready_i
);

   localparam int DEPTH = 2**PEND_W;
   localparam logic [PEND_W:0] FULL = (PEND_W+1)'(DEPTH);

   logic              prio;
   logic              gnt_vld;
   logic              gnt_id;
   logic              gnt_rd;
   logic              blocked;
   logic              accept;
   logic              push;
   logic              pop;
   logic              head_id;

   logic [PEND_W-1:0] wptr_q, wptr_d;
   logic [PEND_W-1:0] rptr_q, rptr_d;
   logic [PEND_W:0]   cnt_q, cnt_d;
   logic              id_mem_q [DEPTH];

`ifdef EXT_MEM_MERGE_FIXED_PRIO_EN
   assign prio = 1'b1;
`else
   logic prio_q, prio_d;

   assign prio   = prio_q;
   assign prio_d = accept ? ~gnt_id : prio_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q <= 1'b0;
      end else if (cke_i) begin
         prio_q <= prio_d;
      end
   end
`endif

   // With no request gnt_id falls to 0 so the slave sees m0's fields.
   assign gnt_vld = m0_avalid_i | m1_avalid_i;
   assign gnt_id  = (m0_avalid_i & m1_avalid_i) ? prio : m1_avalid_i;
   assign gnt_rd  = gnt_id ? (m1_wstrb_i == '0) : (m0_wstrb_i == '0);
   assign blocked = gnt_rd & (cnt_q == FULL);

   assign s_avalid_o = gnt_vld & ~blocked;
   assign s_addr_o   = gnt_id ? m1_addr_i  : m0_addr_i;
   assign s_wdata_o  = gnt_id ? m1_wdata_i : m0_wdata_i;
   assign s_wstrb_o  = gnt_id ? m1_wstrb_i : m0_wstrb_i;

   assign m0_ready_o = s_ready_i & gnt_vld & ~gnt_id & ~blocked;
   assign m1_ready_o = s_ready_i & gnt_vld &  gnt_id & ~blocked;

   assign accept  = s_avalid_o & s_ready_i;
   assign push    = accept & gnt_rd;
   // A response with nothing outstanding is dropped rather than routed.
   assign pop     = s_rvalid_i & (cnt_q != '0);
   assign head_id = id_mem_q[rptr_q];

   assign m0_rvalid_o = pop & ~head_id;
   assign m1_rvalid_o = pop &  head_id;
   assign m0_rdata_o  = s_rdata_i;
   assign m1_rdata_o  = s_rdata_i;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      if (push && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (cke_i) begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && cke_i && push) begin
         id_mem_q[wptr_q] <= gnt_id;
      end
   end

   always @(posedge clk_i) begin
      if (!rst_i && cke_i) begin
         assert (!(s_rvalid_i && cnt_q == '0))
            else $warning("ext_mem_rr_merge: s_rvalid_i with no outstanding read, ignored");
      end
   end

endmodule

// File: tb/tb_ext_mem_rr_merge.sv
// Directed bench for ext_mem_rr_merge: grant, blocking, response routing, reset and clock-enable behaviour.
module tb_ext_mem_rr_merge;

`ifdef EXT_MEM_MERGE_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        cke_i, rst_i;
   logic        m0_avalid_i, m1_avalid_i;
   logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
   logic [3:0]  m0_wstrb_i, m1_wstrb_i;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        m0_rvalid_o, m1_rvalid_o, m0_ready_o, m1_ready_o;
   logic        s_avalid_o;
   logic [31:0] s_addr_o, s_wdata_o;
   logic [3:0]  s_wstrb_o;
   logic [31:0] s_rdata_i;
   logic        s_rvalid_i, s_ready_i;

   int n_tests = 0;
   int n_fail  = 0;
   logic g;

   always #5 clk_i = ~clk_i;

   ext_mem_rr_merge #(.ADDR_W(32), .DATA_W(32), .PEND_W(2)) dut (
      .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i),
      .m0_avalid_i(m0_avalid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i),
      .m0_rdata_o(m0_rdata_o), .m0_rvalid_o(m0_rvalid_o), .m0_ready_o(m0_ready_o),
      .m1_avalid_i(m1_avalid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i),
      .m1_rdata_o(m1_rdata_o), .m1_rvalid_o(m1_rvalid_o), .m1_ready_o(m1_ready_o),
      .s_avalid_o(s_avalid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
      .s_rdata_i(s_rdata_i), .s_rvalid_i(s_rvalid_i), .s_ready_i(s_ready_i)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i       = 1'b1;
      m0_avalid_i = 1'b0;
      m1_avalid_i = 1'b0;
      s_rvalid_i  = 1'b0;
      cyc();
      rst_i = 1'b0;
   endtask

   initial begin
      cke_i = 1'b1; rst_i = 1'b1;
      m0_avalid_i = 0; m0_addr_i = 0; m0_wdata_i = 0; m0_wstrb_i = 0;
      m1_avalid_i = 0; m1_addr_i = 0; m1_wdata_i = 0; m1_wstrb_i = 0;
      s_rdata_i = 0; s_rvalid_i = 0; s_ready_i = 0;
      cyc(); cyc();
      rst_i = 1'b0;

      // reset: empty FIFO ignores a response
      s_rvalid_i = 1'b1; s_rdata_i = 32'h1111_1111;
      #1;
      chk("rst_m0_rvalid", m0_rvalid_o, 0);
      chk("rst_m1_rvalid", m1_rvalid_o, 0);
      chk("rst_s_avalid", s_avalid_o, 0);
      cyc();
      s_rvalid_i = 1'b0;

      // single m0 read, response next cycle
      m0_avalid_i = 1; m0_addr_i = 32'h100; m0_wstrb_i = 0; s_ready_i = 1;
      #1;
      chk("t1_s_avalid", s_avalid_o, 1);
      chk("t1_s_addr", s_addr_o, 32'h100);
      chk("t1_m0_ready", m0_ready_o, 1);
      chk("t1_m1_ready", m1_ready_o, 0);
      cyc();
      m0_avalid_i = 0; s_rvalid_i = 1; s_rdata_i = 32'hDEAD_BEEF;
      #1;
      chk("t1_m0_rvalid", m0_rvalid_o, 1);
      chk("t1_m1_rvalid", m1_rvalid_o, 0);
      chk("t1_m0_rdata", m0_rdata_o, 32'hDEAD_BEEF);
      chk("t1_m1_rdata", m1_rdata_o, 32'hDEAD_BEEF);
      cyc();

      // alternating grants with both masters reading
      do_reset();
      m0_avalid_i = 1; m0_addr_i = 32'h200; m0_wstrb_i = 0;
      m1_avalid_i = 1; m1_addr_i = 32'h300; m1_wstrb_i = 0;
      for (int i = 0; i < 4; i++) begin
         g = FIXED ? 1'b1 : 1'(i % 2);
         #1;
         chk("t2_s_addr", s_addr_o, g ? 32'h300 : 32'h200);
         chk("t2_m0_ready", m0_ready_o, {31'd0, ~g});
         chk("t2_m1_ready", m1_ready_o, {31'd0, g});
         cyc();
      end
      m0_avalid_i = 0; m1_avalid_i = 0;
      for (int i = 0; i < 4; i++) begin
         g = FIXED ? 1'b1 : 1'(i % 2);
         s_rvalid_i = 1; s_rdata_i = i;
         #1;
         chk("t2_m0_rvalid", m0_rvalid_o, {31'd0, ~g});
         chk("t2_m1_rvalid", m1_rvalid_o, {31'd0, g});
         cyc();
      end
      s_rvalid_i = 0;

      // FIFO full blocks reads, writes still pass
      m1_avalid_i = 1; m1_addr_i = 32'h500; m1_wstrb_i = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t3_fill_m1_ready", m1_ready_o, 1);
         cyc();
      end
      #1;
      chk("t3_full_m1_ready", m1_ready_o, 0);
      chk("t3_full_s_avalid", s_avalid_o, 0);
      m0_avalid_i = 1; m0_addr_i = 32'h400; m0_wstrb_i = 4'hF; m0_wdata_i = 32'h1234_5678;
      #1;
      chk("t3_wr_s_avalid", s_avalid_o, 1);
      chk("t3_wr_s_addr", s_addr_o, 32'h400);
      chk("t3_wr_s_wstrb", s_wstrb_o, 4'hF);
      chk("t3_wr_s_wdata", s_wdata_o, 32'h1234_5678);
      chk("t3_wr_m0_ready", m0_ready_o, 1);
      chk("t3_wr_m1_ready", m1_ready_o, 0);
      cyc();
      m0_avalid_i = 0; s_rvalid_i = 1; s_rdata_i = 32'hA5A5_A5A5;
      #1;
      chk("t3_pop_m1_rvalid", m1_rvalid_o, 1);
      chk("t3_pop_m0_rvalid", m0_rvalid_o, 0);
      chk("t3_pop_m1_ready", m1_ready_o, 0);
      cyc();
      s_rvalid_i = 0;
      #1;
      chk("t3_freed_m1_ready", m1_ready_o, 1);
      chk("t3_freed_s_avalid", s_avalid_o, 1);
      cyc();
      m1_avalid_i = 0;
      for (int i = 0; i < 4; i++) begin
         s_rvalid_i = 1;
         #1;
         chk("t3_drain_m1_rvalid", m1_rvalid_o, 1);
         cyc();
      end
      s_rvalid_i = 0;

      // simultaneous push and pop with two m0 reads queued
      m0_avalid_i = 1; m0_addr_i = 32'h600; m0_wstrb_i = 0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("t4_m0_ready", m0_ready_o, 1);
         cyc();
      end
      m0_avalid_i = 0; m1_avalid_i = 1; m1_addr_i = 32'h700; m1_wstrb_i = 0; s_rvalid_i = 1;
      #1;
      chk("t4_pp_m0_rvalid", m0_rvalid_o, 1);
      chk("t4_pp_m1_rvalid", m1_rvalid_o, 0);
      chk("t4_pp_m1_ready", m1_ready_o, 1);
      cyc();
      m1_avalid_i = 0;
      #1;
      chk("t4_older_m0_rvalid", m0_rvalid_o, 1);
      cyc();
      #1;
      chk("t4_new_m1_rvalid", m1_rvalid_o, 1);
      cyc();
      #1;
      chk("t4_empty_m0_rvalid", m0_rvalid_o, 0);
      chk("t4_empty_m1_rvalid", m1_rvalid_o, 0);
      cyc();
      s_rvalid_i = 0;

      // slave stall: no ready, no push, prio held
      s_ready_i = 0;
      m0_avalid_i = 1; m0_addr_i = 32'h800; m0_wstrb_i = 0;
      m1_avalid_i = 1; m1_addr_i = 32'h900; m1_wstrb_i = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t5_stall_m0_ready", m0_ready_o, 0);
         chk("t5_stall_m1_ready", m1_ready_o, 0);
         chk("t5_stall_s_addr", s_addr_o, FIXED ? 32'h900 : 32'h800);
         cyc();
      end
      s_ready_i = 1;
      #1;
      chk("t5_go_m0_ready", m0_ready_o, {31'd0, ~FIXED});
      chk("t5_go_m1_ready", m1_ready_o, {31'd0, FIXED});
      cyc();
      m0_avalid_i = 0; m1_avalid_i = 0; s_rvalid_i = 1;
      #1;
      chk("t5_rsp_m0_rvalid", m0_rvalid_o, {31'd0, ~FIXED});
      chk("t5_rsp_m1_rvalid", m1_rvalid_o, {31'd0, FIXED});
      cyc();
      #1;
      chk("t5_nopush_m0_rvalid", m0_rvalid_o, 0);
      chk("t5_nopush_m1_rvalid", m1_rvalid_o, 0);
      cyc();
      s_rvalid_i = 0;

      // reset with reads outstanding
      m0_avalid_i = 1; m0_addr_i = 32'hA00; m0_wstrb_i = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t6_m0_ready", m0_ready_o, 1);
         cyc();
      end
      do_reset();
      s_rvalid_i = 1;
      #1;
      chk("t6_stray_m0_rvalid", m0_rvalid_o, 0);
      chk("t6_stray_m1_rvalid", m1_rvalid_o, 0);
      cyc();
      s_rvalid_i = 0; m1_avalid_i = 1; m1_addr_i = 32'hB00; m1_wstrb_i = 0;
      #1;
      chk("t6_m1_ready", m1_ready_o, 1);
      cyc();
      m1_avalid_i = 0; s_rvalid_i = 1;
      #1;
      chk("t6_rsp_m1_rvalid", m1_rvalid_o, 1);
      cyc();
      #1;
      chk("t6_cnt0_m1_rvalid", m1_rvalid_o, 0);
      cyc();
      s_rvalid_i = 0;

      // clock enable low freezes prio and count
      do_reset();
      cke_i = 0;
      m0_avalid_i = 1; m0_addr_i = 32'hC00; m0_wstrb_i = 0;
      m1_avalid_i = 1; m1_addr_i = 32'hD00; m1_wstrb_i = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t7_frz_s_addr", s_addr_o, FIXED ? 32'hD00 : 32'hC00);
         cyc();
      end
      cke_i = 1; m0_avalid_i = 0; m1_avalid_i = 0; s_rvalid_i = 1;
      #1;
      chk("t7_frz_m0_rvalid", m0_rvalid_o, 0);
      chk("t7_frz_m1_rvalid", m1_rvalid_o, 0);
      cyc();
      s_rvalid_i = 0; m0_avalid_i = 1; m1_avalid_i = 1;
      #1;
      chk("t7_prio_s_addr", s_addr_o, FIXED ? 32'hD00 : 32'hC00);
      cyc();
      m0_avalid_i = 0; m1_avalid_i = 0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
